// File: rtl/sr_ff.sv
// rtl/sr_ff.sv - clocked SR flip-flop bank with true/complement outputs
// Optional sticky overlap flag err when SR_FF_ERR_EN is defined.
module sr_ff #(
  parameter int WIDTH        = 1,
  parameter int RESET_VALUE  = 0,
  parameter int ILLEGAL_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
`ifdef SR_FF_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic RST_BIT = (RESET_VALUE != 0);

  logic [WIDTH-1:0] q_next;

  // s=r=1 resolution is fixed at elaboration; out-of-range modes fall back to hold
  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s[i], r[i]})
        2'b10: q_next[i] = 1'b1;
        2'b01: q_next[i] = 1'b0;
        2'b11: begin
          case (ILLEGAL_MODE)
            1:       q_next[i] = 1'b0;
            2:       q_next[i] = 1'b1;
            3:       q_next[i] = ~q[i];
            default: q_next[i] = q[i];
          endcase
        end
        default: q_next[i] = q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {WIDTH{RST_BIT}};
    end else begin
      q <= q_next;
    end
  end

  assign qb = ~q;

`ifdef SR_FF_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((s & r) != '0) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_ff.sv
// tb/tb_sr_ff.sv - scoreboard bench for sr_ff across hold/toggle/set-wins/reset-wins variants
// err checks are compiled in when SR_FF_ERR_EN is defined.
module tb_sr_ff;

  logic       clk;
  logic       rst;
  logic       s1, r1;
  logic [3:0] s4, r4;
  logic       q0, qb0, q3, qb3, q2, qb2;
  logic [3:0] q4, qb4;
`ifdef SR_FF_ERR_EN
  logic       e0, e3, e2, e4;
`endif

  sr_ff dut0 (.clk(clk), .rst(rst), .s(s1), .r(r1), .q(q0), .qb(qb0)
`ifdef SR_FF_ERR_EN
    , .err(e0)
`endif
  );
  sr_ff #(.ILLEGAL_MODE(3)) dut3 (.clk(clk), .rst(rst), .s(s1), .r(r1), .q(q3), .qb(qb3)
`ifdef SR_FF_ERR_EN
    , .err(e3)
`endif
  );
  sr_ff #(.ILLEGAL_MODE(2)) dut2 (.clk(clk), .rst(rst), .s(s1), .r(r1), .q(q2), .qb(qb2)
`ifdef SR_FF_ERR_EN
    , .err(e2)
`endif
  );
  sr_ff #(.WIDTH(4), .RESET_VALUE(1), .ILLEGAL_MODE(1)) dut4 (.clk(clk), .rst(rst), .s(s4), .r(r4), .q(q4), .qb(qb4)
`ifdef SR_FF_ERR_EN
    , .err(e4)
`endif
  );

  typedef struct {
    logic       q0, q3, q2;
    logic [3:0] q4;
    logic       e1, e4;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic nxt(input logic q, input logic sv, input logic rv, input int mode);
    if (sv && !rv) return 1'b1;
    if (rv && !sv) return 1'b0;
    if (!sv && !rv) return q;
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    if (mode == 3) return ~q;
    return q;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m.q0 = 1'b0; m.q3 = 1'b0; m.q2 = 1'b0; m.q4 = 4'b1111; m.e1 = 1'b0; m.e4 = 1'b0;
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".q0"},  {3'b0, q0},  {3'b0, e.q0});
    chk({tag, ".qb0"}, {3'b0, qb0}, {3'b0, ~e.q0});
    chk({tag, ".q3"},  {3'b0, q3},  {3'b0, e.q3});
    chk({tag, ".qb3"}, {3'b0, qb3}, {3'b0, ~e.q3});
    chk({tag, ".q2"},  {3'b0, q2},  {3'b0, e.q2});
    chk({tag, ".qb2"}, {3'b0, qb2}, {3'b0, ~e.q2});
    chk({tag, ".q4"},  q4,  e.q4);
    chk({tag, ".qb4"}, qb4, ~e.q4);
`ifdef SR_FF_ERR_EN
    chk({tag, ".err0"}, {3'b0, e0}, {3'b0, e.e1});
    chk({tag, ".err3"}, {3'b0, e3}, {3'b0, e.e1});
    chk({tag, ".err2"}, {3'b0, e2}, {3'b0, e.e1});
    chk({tag, ".err4"}, {3'b0, e4}, {3'b0, e.e4});
`endif
  endtask

  // Drives one clock edge worth of s/r (rst low), predicts, then compares after the edge
  task automatic step(input string tag, input logic sv, input logic rv,
                      input logic [3:0] sv4, input logic [3:0] rv4);
    s1 = sv; r1 = rv; s4 = sv4; r4 = rv4;
    m.q0 = nxt(m.q0, sv, rv, 0);
    m.q3 = nxt(m.q3, sv, rv, 3);
    m.q2 = nxt(m.q2, sv, rv, 2);
    for (int i = 0; i < 4; i++) m.q4[i] = nxt(m.q4[i], sv4[i], rv4[i], 1);
    if (sv && rv) m.e1 = 1'b1;
    if ((sv4 & rv4) != 4'b0) m.e4 = 1'b1;
    sb.push_back(m);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; s1 = 1'b0; r1 = 1'b0; s4 = 4'b0; r4 = 4'b0;
    model_reset();
    #2;
    sb.push_back(m);
    check_pop("reset_immediate");

    s1 = 1'b1; s4 = 4'b0101; r4 = 4'b1010;
    @(posedge clk); @(posedge clk); #1;
    sb.push_back(m);
    check_pop("reset_hold");

    rst = 1'b0; s1 = 1'b0; s4 = 4'b0; r4 = 4'b0;
    step("set",        1'b1, 1'b0, 4'b0000, 4'b0001);
    step("hold1a",     1'b0, 1'b0, 4'b0000, 4'b0000);
    step("hold1b",     1'b0, 1'b0, 4'b0000, 4'b0000);
    step("clr",        1'b0, 1'b1, 4'b0000, 4'b1000);
    step("hold0",      1'b0, 1'b0, 4'b0000, 4'b0000);
    step("both_a",     1'b1, 1'b1, 4'b0010, 4'b0010);
    step("both_b",     1'b1, 1'b1, 4'b0000, 4'b0000);
    step("both_c",     1'b1, 1'b1, 4'b0100, 4'b0000);
    step("err_sticky", 1'b0, 1'b0, 4'b0000, 4'b0000);
    step("mixed4",     1'b1, 1'b0, 4'b1011, 4'b0100);

    #2;
    rst = 1'b1;
    model_reset();
    #1;
    sb.push_back(m);
    check_pop("rst_async");

    s1 = 1'b1; r1 = 1'b0; s4 = 4'b0000; r4 = 4'b1111;
    @(posedge clk); #1;
    sb.push_back(m);
    check_pop("rst_discard");

    rst = 1'b0;
    step("post_release", 1'b1, 1'b0, 4'b0000, 4'b0110);
    step("final_hold",   1'b0, 1'b0, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
